// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front end: select codes,
// header field positions and the command FSM state encoding.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  localparam int unsigned HDR_SEL_LSB   = 0;
  localparam int unsigned HDR_SEL_MSB   = 2;
  localparam int unsigned HDR_USE_ACC   = 3;
  localparam int unsigned HDR_KEEP      = 4;
  localparam logic [7:0]  HDR_RSVD_MASK = 8'hE0;

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_RESP = 3'd4
  } state_t;

endpackage

// File: rtl/alu_cmd_driver.sv
// Byte-serial command front end for the 8-bit ALU.
//
// state  | meaning
// S_HDR  | waiting for header byte (sel / use_acc / keep)
// S_A    | waiting for operand A byte
// S_B    | waiting for operand B byte
// S_EXEC | ALU inputs stable for one cycle, result captured at its end
// S_RESP | response held on out_* until out_ready
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter logic [7:0] ACC_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_result,
  output logic       out_zero,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_zero
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_acc;
  logic       r_use_acc;
  logic       r_keep;
  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic [2:0] r_alu_sel;
  logic [7:0] r_result;
  logic       r_zero;
  logic       r_out_valid;
  logic       r_err;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_hdr_bad;

  assign w_in_ready = (r_state == S_HDR) || (r_state == S_A) || (r_state == S_B);
  assign w_accept   = in_valid && w_in_ready;
  assign w_hdr_bad  = |(in_data & HDR_RSVD_MASK);

  assign in_ready   = w_in_ready;
  assign out_result = r_result;
  assign out_zero   = r_zero;
  assign out_valid  = r_out_valid;
  assign err        = r_err;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HDR;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; a malformed header leaves the FSM waiting for a header.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR: begin
        if (w_accept && !w_hdr_bad)
          w_state_nxt = in_data[HDR_USE_ACC] ? S_B : S_A;
      end
      S_A:    if (w_accept) w_state_nxt = S_B;
      S_B:    if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC: w_state_nxt = S_RESP;
      S_RESP: if (out_ready) w_state_nxt = S_HDR;
      default: w_state_nxt = S_HDR;
    endcase
  end

  // Operand, header, accumulator and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= ACC_INIT;
      r_use_acc   <= 1'b0;
      r_keep      <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_HDR: begin
          if (w_accept) begin
            if (w_hdr_bad) begin
              r_err <= 1'b1;
            end else begin
              r_alu_sel <= in_data[HDR_SEL_MSB:HDR_SEL_LSB];
              r_use_acc <= in_data[HDR_USE_ACC];
              r_keep    <= in_data[HDR_KEEP];
              if (in_data[HDR_USE_ACC]) r_alu_a <= r_acc;
            end
          end
        end
        S_A: if (w_accept) r_alu_a <= in_data;
        S_B: if (w_accept) r_alu_b <= in_data;
        S_EXEC: begin
          r_result    <= alu_out;
          r_zero      <= alu_zero;
          r_out_valid <= 1'b1;
          if (r_keep) r_acc <= alu_out;
        end
        S_RESP: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
